// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU-side requesters and memory_responder.
// The bidirectional data2 bus stays a plain module inout so it can be resolved at the top.
interface memory_responder_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 readM2;
    logic                 writeM2;
    logic [WORD_SIZE-1:0] address2;
    logic                 load_en;
    logic [WORD_SIZE-1:0] load_addr;
    logic [WORD_SIZE-1:0] load_data;
    logic                 mem_ready;
    logic [CNT_WIDTH-1:0] rd1_count;
    logic [CNT_WIDTH-1:0] rd2_count;
    logic [CNT_WIDTH-1:0] wr2_count;
    logic                 conflict;

    modport master (
        output readM1, address1, readM2, writeM2, address2,
               load_en, load_addr, load_data,
        input  data1, mem_ready, rd1_count, rd2_count, wr2_count, conflict
    );

    modport slave (
        input  readM1, address1, readM2, writeM2, address2,
               load_en, load_addr, load_data,
        output data1, mem_ready, rd1_count, rd2_count, wr2_count, conflict
    );
endinterface

// File: rtl/memory_responder.sv
// Responder for the CPU instruction-fetch port and read/write data port, with a
// post-reset clearing sequence, a preload port and saturating access counters.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    memory_responder_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data2
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_BITS-1:0] PTR_LAST  = {ADDR_BITS{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [WORD_SIZE-1:0] WORD_ZERO = {WORD_SIZE{1'b0}};

    logic [0:0]           state_r;
    logic [ADDR_BITS-1:0] init_ptr_r;
    logic                 mem_ready_r;
    logic [CNT_WIDTH-1:0] rd1_cnt_r;
    logic [CNT_WIDTH-1:0] rd2_cnt_r;
    logic [CNT_WIDTH-1:0] wr2_cnt_r;
    logic                 conflict_r;
    logic [WORD_SIZE-1:0] mem_r [DEPTH];

    logic [ADDR_BITS-1:0] idx1_s;
    logic [ADDR_BITS-1:0] idx2_s;
    logic [ADDR_BITS-1:0] idx_ld_s;
    logic                 ready_s;
    logic                 rd1_srv_s;
    logic                 rd2_srv_s;
    logic                 wr2_srv_s;
    logic                 ld_srv_s;
    logic                 conf_s;
    logic [WORD_SIZE-1:0] data1_s;
    logic [WORD_SIZE-1:0] rd2_word_s;
    logic                 unused_addr_hi_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 en
    );
        logic [CNT_WIDTH-1:0] nxt;
        if (en && (cnt != CNT_MAX)) begin
            nxt = cnt + CNT_ONE;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Upper address bits are deliberately ignored, so accesses wrap modulo DEPTH.
    assign idx1_s   = bus.address1[ADDR_BITS-1:0];
    assign idx2_s   = bus.address2[ADDR_BITS-1:0];
    assign idx_ld_s = bus.load_addr[ADDR_BITS-1:0];
    assign unused_addr_hi_s = ^{bus.address1[WORD_SIZE-1:ADDR_BITS],
                                bus.address2[WORD_SIZE-1:ADDR_BITS],
                                bus.load_addr[WORD_SIZE-1:ADDR_BITS]};

    // Request qualification: nothing is served until the clearing sequence completes.
    always_comb begin
        ready_s   = 1'b0;
        rd1_srv_s = 1'b0;
        rd2_srv_s = 1'b0;
        wr2_srv_s = 1'b0;
        ld_srv_s  = 1'b0;
        conf_s    = 1'b0;
        if (state_r == ST_READY) begin
            ready_s   = 1'b1;
            rd1_srv_s = bus.readM1;
            rd2_srv_s = bus.readM2 & ~bus.writeM2;
            wr2_srv_s = bus.writeM2;
            ld_srv_s  = bus.load_en;
            conf_s    = bus.readM2 & bus.writeM2;
        end else begin
            ready_s   = 1'b0;
        end
    end

    // Zero-latency read data for both ports; the CPU samples in the same cycle.
    always_comb begin
        data1_s    = WORD_ZERO;
        rd2_word_s = WORD_ZERO;
        if (rd1_srv_s) begin
            data1_s = mem_r[idx1_s];
        end else begin
            data1_s = WORD_ZERO;
        end
        if (rd2_srv_s) begin
            rd2_word_s = mem_r[idx2_s];
        end else begin
            rd2_word_s = WORD_ZERO;
        end
    end

    assign bus.data1 = data1_s;
    // A combined read+write request never drives the bus: the requester owns it for the write.
    assign data2     = rd2_srv_s ? rd2_word_s : {WORD_SIZE{1'bz}};

    // Clearing sequence: one word per clock, then READY until the next reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            init_ptr_r  <= {ADDR_BITS{1'b0}};
            mem_ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                    if (init_ptr_r == PTR_LAST) begin
                        state_r     <= ST_READY;
                        mem_ready_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        mem_ready_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_r     <= ST_READY;
                    init_ptr_r  <= init_ptr_r;
                    mem_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_ptr_r  <= {ADDR_BITS{1'b0}};
                    mem_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage update; the preload is written last so it wins a same-index collision with port 2.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[init_ptr_r] <= WORD_ZERO;
        end else begin
            if (wr2_srv_s) begin
                mem_r[idx2_s] <= data2;
            end
            if (ld_srv_s) begin
                mem_r[idx_ld_s] <= bus.load_data;
            end
        end
    end

    // Access counters and the sticky read/write conflict flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_cnt_r  <= CNT_ZERO;
            rd2_cnt_r  <= CNT_ZERO;
            wr2_cnt_r  <= CNT_ZERO;
            conflict_r <= 1'b0;
        end else begin
            rd1_cnt_r  <= sat_inc(rd1_cnt_r, rd1_srv_s);
            rd2_cnt_r  <= sat_inc(rd2_cnt_r, rd2_srv_s);
            wr2_cnt_r  <= sat_inc(wr2_cnt_r, wr2_srv_s);
            conflict_r <= conflict_r | (conf_s & ready_s);
        end
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.rd1_count = rd1_cnt_r;
    assign bus.rd2_count = rd2_cnt_r;
    assign bus.wr2_count = wr2_cnt_r;
    assign bus.conflict  = conflict_r;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed vector table, randomized traffic against a
// word-array reference model, reset/init timing and counter saturation on a narrow instance.
module tb_memory_responder;
    localparam int DEPTH = 256;
    localparam int CMAX  = 65535;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    memory_responder_if #(.WORD_SIZE(16), .CNT_WIDTH(16)) bus ();
    wire  [15:0] data2;
    logic        tb_drv;
    logic [15:0] tb_d2;
    assign data2 = tb_drv ? tb_d2 : {16{1'bz}};

    memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .data2(data2)
    );

    // Narrow instance: 16 words, 4-bit counters, so saturation is reachable quickly.
    memory_responder_if #(.WORD_SIZE(16), .CNT_WIDTH(4)) sbus ();
    wire [15:0] sdata2;
    assign sdata2 = sbus.writeM2 ? 16'h0000 : {16{1'bz}};

    memory_responder #(.WORD_SIZE(16), .ADDR_BITS(4), .CNT_WIDTH(4)) sdut (
        .clk(clk), .reset_n(reset_n), .bus(sbus), .data2(sdata2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    int          ref_rd1, ref_rd2, ref_wr2, ref_edges;
    logic        ref_conf;

    logic        cur_rm1, cur_rm2, cur_wm2, cur_ld;
    logic [15:0] cur_a1, cur_a2, cur_d2, cur_la, cur_ldd;

    typedef struct {
        logic rm1; logic [15:0] a1;
        logic rm2; logic wm2; logic [15:0] a2; logic [15:0] d2;
        logic ld;  logic [15:0] la; logic [15:0] ldd;
        logic [15:0] e_d1; logic chk_d2; logic [15:0] e_d2;
        int e_rd1; int e_rd2; int e_wr2; logic e_conf;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic rm1, input logic [15:0] a1, input logic rm2, input logic wm2,
                         input logic [15:0] a2, input logic [15:0] d2, input logic ld,
                         input logic [15:0] la, input logic [15:0] ldd);
        cur_rm1 = rm1; cur_a1 = a1; cur_rm2 = rm2; cur_wm2 = wm2; cur_a2 = a2;
        cur_d2 = d2; cur_ld = ld; cur_la = la; cur_ldd = ldd;
        bus.readM1 = rm1; bus.address1 = a1; bus.readM2 = rm2; bus.writeM2 = wm2;
        bus.address2 = a2; bus.load_en = ld; bus.load_addr = la; bus.load_data = ldd;
        tb_drv = wm2; tb_d2 = d2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Effect of one rising edge on the model, from the behavioural rules.
    task automatic model_edge();
        if (ref_edges >= DEPTH) begin
            if (cur_wm2) ref_mem[int'(cur_a2) % DEPTH] = cur_d2;
            if (cur_ld)  ref_mem[int'(cur_la) % DEPTH] = cur_ldd;
            if (cur_rm1 && ref_rd1 < CMAX) ref_rd1++;
            if (cur_rm2 && !cur_wm2 && ref_rd2 < CMAX) ref_rd2++;
            if (cur_wm2 && ref_wr2 < CMAX) ref_wr2++;
            if (cur_rm2 && cur_wm2) ref_conf = 1'b1;
        end
        ref_edges++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        ref_rd1 = 0; ref_rd2 = 0; ref_wr2 = 0; ref_conf = 1'b0; ref_edges = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_rd1"},   {16'h0000, bus.rd1_count}, ref_rd1);
        check({tag, "_rd2"},   {16'h0000, bus.rd2_count}, ref_rd2);
        check({tag, "_wr2"},   {16'h0000, bus.wr2_count}, ref_wr2);
        check({tag, "_conf"},  {31'd0, bus.conflict},  {31'd0, ref_conf});
        check({tag, "_ready"}, {31'd0, bus.mem_ready}, {31'd0, (ref_edges >= DEPTH)});
    endtask

    task automatic cycle_check(input string tag, input logic rm1, input logic [15:0] a1,
                               input logic rm2, input logic wm2, input logic [15:0] a2,
                               input logic [15:0] d2, input logic ld, input logic [15:0] la,
                               input logic [15:0] ldd);
        logic [15:0] e_d1;
        drive(rm1, a1, rm2, wm2, a2, d2, ld, la, ldd);
        e_d1 = ((ref_edges >= DEPTH) && rm1) ? ref_mem[int'(a1) % DEPTH] : 16'h0000;
        check({tag, "_data1"}, {16'h0000, bus.data1}, {16'h0000, e_d1});
        if (wm2) check({tag, "_data2_undriven"}, {16'h0000, data2}, {16'h0000, d2});
        else if (rm2 && (ref_edges >= DEPTH))
            check({tag, "_data2"}, {16'h0000, data2}, {16'h0000, ref_mem[int'(a2) % DEPTH]});
        model_edge();
        @(posedge clk); #1;
        check_regs(tag);
    endtask

    // Asserts reset with requests pending, checks the cleared state, then releases.
    task automatic do_reset();
        drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0003, 16'hC3C3, 1'b1, 16'h0004, 16'h7777);
        reset_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_counts", {bus.rd1_count | bus.rd2_count | bus.wr2_count, 15'd0, bus.conflict}, 32'd0);
        check("rst_data1", {16'h0000, bus.data1}, 32'd0);
        check("rst_data2_undriven", {16'h0000, data2}, 32'h0000C3C3);
        @(posedge clk); #1;
        check("rst_edge_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_edge_counts", {bus.rd1_count | bus.wr2_count, 15'd0, bus.conflict}, 32'd0);
        idle();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_ready();
        int n;
        int sm_n;
        n = 0; sm_n = -1;
        while (!bus.mem_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (sm_n < 0 && sbus.mem_ready) sm_n = n;
        end
        check("ready_latency", n, 32'd256);
        check("small_ready_latency", sm_n, 32'd16);
        ref_edges = DEPTH;
    endtask

    task automatic sweep_zero(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
            if (bus.data1 !== 16'h0000) bad++;
            model_edge();
            @(posedge clk); #1;
        end
        check(name, bad, 32'd0);
        check({name, "_rd1"}, {16'h0000, bus.rd1_count}, 32'd256);
    endtask

    initial begin
        reset_n = 1'b0;
        sbus.readM1 = 1'b0; sbus.address1 = 16'h0000; sbus.readM2 = 1'b0; sbus.writeM2 = 1'b0;
        sbus.address2 = 16'h0000; sbus.load_en = 1'b0; sbus.load_addr = 16'h0000;
        sbus.load_data = 16'h0000;
        idle();
        @(posedge clk); #1;

        // Power-up, junk preload, then reset again: memory must be cleared
        do_reset();
        wait_ready();
        for (int i = 0; i < 8; i++)
            cycle_check("junk", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                        1'b1, 16'(i * 29), 16'($urandom_range(1, 65535)));
        do_reset();
        wait_ready();
        sweep_zero("clear_sweep");

        // Directed vector table from a fresh reset
        do_reset();
        wait_ready();
        vecs[0]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 16'h0000, 0, 0, 0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1, 0, 0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0120, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1, 0, 1, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1, 1, 1, 1'b0};
        vecs[4]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hAAAA, 2, 1, 2, 1'b0};
        vecs[5]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 1'b0, 16'h0000, 3, 1, 2, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0007, 16'h2222, 16'h0000, 1'b0, 16'h0000, 3, 1, 2, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'h5555, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h5555, 3, 1, 3, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h5555, 3, 2, 3, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0130, 16'h9999, 1'b1, 16'h0030, 16'h1111, 16'h0000, 1'b1, 16'h9999, 3, 2, 4, 1'b1};
        vecs[10] = '{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 16'h0000, 4, 2, 4, 1'b1};
        vecs[11] = '{1'b1, 16'hFF05, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 1'b0, 16'h0000, 5, 2, 4, 1'b1};
        vecs[12] = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5, 2, 4, 1'b1};
        vecs[13] = '{1'b1, 16'h0107, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 16'h0000, 6, 2, 4, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0130, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h1111, 6, 3, 4, 1'b1};
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rm1, vecs[i].a1, vecs[i].rm2, vecs[i].wm2, vecs[i].a2, vecs[i].d2,
                  vecs[i].ld, vecs[i].la, vecs[i].ldd);
            check($sformatf("vec%0d_data1", i), {16'h0000, bus.data1}, {16'h0000, vecs[i].e_d1});
            if (vecs[i].chk_d2)
                check($sformatf("vec%0d_data2", i), {16'h0000, data2}, {16'h0000, vecs[i].e_d2});
            model_edge();
            @(posedge clk); #1;
            check($sformatf("vec%0d_rd1", i), {16'h0000, bus.rd1_count}, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), {16'h0000, bus.rd2_count}, vecs[i].e_rd2);
            check($sformatf("vec%0d_wr2", i), {16'h0000, bus.wr2_count}, vecs[i].e_wr2);
            check($sformatf("vec%0d_conf", i), {31'd0, bus.conflict}, {31'd0, vecs[i].e_conf});
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int op;
            logic [15:0] a2r;
            logic [15:0] lar;
            op  = int'($urandom_range(0, 9));
            a2r = 16'($urandom);
            lar = ($urandom_range(0, 1) == 0) ? (a2r ^ 16'h0100) : 16'($urandom);
            cycle_check("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                        (op >= 4 && op <= 6) || op == 9, op >= 7, a2r, 16'($urandom),
                        ($urandom_range(0, 7) == 0), lar, 16'($urandom));
        end

        // Reset mid-READY, then requests during INIT (all ignored), then reset at ptr=100
        do_reset();
        for (int i = 0; i < 100; i++)
            cycle_check("init", 1'b1, 16'($urandom), 1'b1, 1'($urandom_range(0, 1)), 16'($urandom),
                        16'($urandom), 1'b1, 16'($urandom), 16'hFFFF);
        do_reset();
        wait_ready();
        sweep_zero("reinit_sweep");

        // Counter saturation on the 4-bit instance
        idle();
        check("small_ready", {31'd0, sbus.mem_ready}, 32'd1);
        sbus.readM1 = 1'b1; sbus.readM2 = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i == 14 || i == 15 || i == 17) begin
                check($sformatf("sat_rd1_%0d", i), {28'd0, sbus.rd1_count}, (i < 15) ? i : 15);
                check($sformatf("sat_rd2_%0d", i), {28'd0, sbus.rd2_count}, (i < 15) ? i : 15);
            end
        end
        sbus.readM1 = 1'b0; sbus.readM2 = 1'b0; sbus.writeM2 = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i == 14 || i == 17)
                check($sformatf("sat_wr2_%0d", i), {28'd0, sbus.wr2_count}, (i < 15) ? i : 15);
        end
        sbus.writeM2 = 1'b0;
        check("sat_rd1_hold", {28'd0, sbus.rd1_count}, 32'd15);
        check("sat_conf", {31'd0, sbus.conflict}, 32'd0);
        check_regs("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
